// File: rtl/alu_pkg.sv
// Shared types for alu_multicycle: opcodes, FSM states and the flag vector.
// Defining ALU_MULTICYCLE_DIV_EN makes DIV a multi-cycle opcode; otherwise it is reserved.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_AND = 4'b0110,
        OP_OR  = 4'b0111,
        OP_XOR = 4'b1000,
        OP_NOT = 4'b1001
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } flags_t;

    function automatic logic is_multi(input logic [3:0] op);
`ifdef ALU_MULTICYCLE_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one {hi, lo} register pair.
// The divider path exists only when ALU_MULTICYCLE_DIV_EN is defined.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         run,
`ifdef ALU_MULTICYCLE_DIV_EN
    input  logic         div_sel,
`endif
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] hi_next,
    output logic [M-1:0] lo_next,
    output logic         last
);
    localparam int CW = $clog2(M);

    logic [M-1:0]  hi;
    logic [M-1:0]  lo;
    logic [M-1:0]  d;
    logic [CW-1:0] cnt;
    logic [M:0]    add_sum;
    logic [M:0]    mul_t;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic          div_q;
    logic [M:0]    shifted;
    logic [M:0]    diff;
`endif

    // MUL: lo holds the multiplier and shifts right into hi's sum.
    // DIV: lo holds the dividend, shifts left and collects quotient bits.
    always_comb begin
        add_sum = {1'b0, hi} + {1'b0, d};
        mul_t   = lo[0] ? add_sum : {1'b0, hi};
        hi_next = mul_t[M:1];
        lo_next = {mul_t[0], lo[M-1:1]};
`ifdef ALU_MULTICYCLE_DIV_EN
        shifted = {hi, lo[M-1]};
        diff    = shifted - {1'b0, d};
        if (div_q) begin
            if (shifted >= {1'b0, d}) begin
                hi_next = diff[M-1:0];
                lo_next = {lo[M-2:0], 1'b1};
            end else begin
                hi_next = shifted[M-1:0];
                lo_next = {lo[M-2:0], 1'b0};
            end
        end
`endif
    end

    assign last = (cnt == CW'(M - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            d     <= '0;
            cnt   <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            hi    <= '0;
            cnt   <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            div_q <= div_sel;
            lo    <= div_sel ? a : b;
            d     <= div_sel ? b : a;
`else
            lo    <= b;
            d     <= a;
`endif
        end else if (run) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops finish on the accepting edge, MUL/DIV iterate one bit per cycle.
// ALU_MULTICYCLE_DIV_EN enables the iterative divider; without it DIV behaves as a reserved opcode.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic [3:0]   ALUControl,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] resultado,
    output logic         Z,
    output logic         N,
    output logic         V,
    output logic         C,
    output state_t       state
);
    // Handshake: a request transfers on a rising edge with in_valid && in_ready, a result
    // transfers on a rising edge with out_valid && out_ready; both may happen on one edge.

    state_t       state_next;
    logic         accept;
    logic         start;
    logic [M-1:0] res_q;
    flags_t       flags_q;
    logic [M:0]   wide;
    logic [M-1:0] sc_res;
    flags_t       sc_flags;
    logic [M-1:0] it_res;
    flags_t       it_flags;
    logic [M-1:0] hi_next;
    logic [M-1:0] lo_next;
    logic         last;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic         div_q;
    logic         dz_q;
`endif

    iter_muldiv #(.M(M)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .run     (state == S_BUSY),
`ifdef ALU_MULTICYCLE_DIV_EN
        .div_sel (ALUControl == OP_DIV),
`endif
        .a       (a),
        .b       (b),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .last    (last)
    );

    always_comb begin
        wide     = '0;
        sc_res   = '0;
        sc_flags = '0;
        case (ALUControl)
            OP_ADD: begin
                wide       = {1'b0, a} + {1'b0, b};
                sc_res     = wide[M-1:0];
                sc_flags.c = wide[M];
                sc_flags.v = (a[M-1] == b[M-1]) && (sc_res[M-1] != a[M-1]);
            end
            OP_SUB: begin
                wide       = {1'b0, a} + {1'b0, ~b} + 1'b1;
                sc_res     = wide[M-1:0];
                sc_flags.c = wide[M];
                sc_flags.v = (a[M-1] != b[M-1]) && (sc_res[M-1] != a[M-1]);
            end
            // The extra bit beside the operand catches the last bit shifted out.
            OP_SLL: begin
                wide       = {1'b0, a} << b;
                sc_res     = wide[M-1:0];
                sc_flags.c = wide[M];
            end
            OP_SRL: begin
                wide       = {a, 1'b0} >> b;
                sc_res     = wide[M:1];
                sc_flags.c = wide[0];
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOT:  sc_res = ~a;
            default: sc_flags.v = 1'b1;
        endcase
        sc_flags.z = (sc_res == '0);
        sc_flags.n = sc_res[M-1];
    end

    always_comb begin
        it_res     = lo_next;
        it_flags   = '0;
        it_flags.v = |hi_next;
`ifdef ALU_MULTICYCLE_DIV_EN
        if (div_q) begin
            it_flags.v = dz_q;
            if (dz_q) it_res = '1;
        end
`endif
        it_flags.z = (it_res == '0);
        it_flags.n = it_res[M-1];
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: in_ready = rst_n;
            S_BUSY: if (last) state_next = S_DONE;
            S_DONE: begin
                in_ready = rst_n && out_ready;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        accept = in_valid && in_ready;
        start  = accept && is_multi(ALUControl);
        if (accept) state_next = start ? S_BUSY : S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            res_q   <= '0;
            flags_q <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept && !start) begin
                res_q   <= sc_res;
                flags_q <= sc_flags;
            end else if (state == S_BUSY && last) begin
                res_q   <= it_res;
                flags_q <= it_flags;
            end
`ifdef ALU_MULTICYCLE_DIV_EN
            if (start) begin
                div_q <= (ALUControl == OP_DIV);
                dz_q  <= (b == '0);
            end
`endif
        end
    end

    assign out_valid = (state == S_DONE);
    assign resultado = res_q;
    assign Z         = flags_q.z;
    assign N         = flags_q.n;
    assign V         = flags_q.v;
    assign C         = flags_q.c;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle at M = 8: arithmetic reference model plus directed vectors.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [3:0]   alu_control;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] resultado;
    logic         Z, N, V, C;
    state_t       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [11:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];

`ifdef ALU_MULTICYCLE_DIV_EN
    localparam logic [11:0] DIV_C8_07 = 12'h1C0;
    localparam logic [11:0] DIV_12_00 = 12'hFF6;
`else
    localparam logic [11:0] DIV_C8_07 = 12'h00A;
    localparam logic [11:0] DIV_12_00 = 12'h00A;
`endif

    alu_multicycle #(.M(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .ALUControl (alu_control),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resultado  (resultado),
        .Z          (Z),
        .N          (N),
        .V          (V),
        .C          (C),
        .state      (dbg_state)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no response within the cycle budget (edge %0d)", name, cyc);
    endtask

    // Reference: {result[7:0], Z, N, V, C} straight from the opcode definitions.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, r, sr;
        logic v, c;
        logic [7:0] res;
        ux = x; uy = y; r = 0; sr = 0; v = 1'b0; c = 1'b0;
        case (op)
            4'd0: begin
                r = ux + uy; c = r > 255;
                sr = int'($signed(x)) + int'($signed(y)); v = (sr > 127) || (sr < -128);
            end
            4'd1: begin
                r = ux + (255 - uy) + 1; c = r > 255;
                sr = int'($signed(x)) - int'($signed(y)); v = (sr > 127) || (sr < -128);
            end
            4'd2: begin r = ux * uy; v = r > 255; end
`ifdef ALU_MULTICYCLE_DIV_EN
            4'd3: begin
                if (uy == 0) begin r = 255; v = 1'b1; end
                else r = ux / uy;
            end
`endif
            4'd4: begin
                if (uy == 0) r = ux;
                else if (uy > 8) r = 0;
                else begin r = ux << uy; c = ((ux >> (8 - uy)) & 1) == 1; end
            end
            4'd5: begin
                if (uy == 0) r = ux;
                else if (uy > 8) r = 0;
                else begin r = ux >> uy; c = ((ux >> (uy - 1)) & 1) == 1; end
            end
            4'd6: r = ux & uy;
            4'd7: r = ux | uy;
            4'd8: r = ux ^ uy;
            4'd9: r = 255 - ux;
            default: begin r = 0; v = 1'b1; end
        endcase
        res = 8'(r);
        return {res, res == 8'd0, res[7], v, c};
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        if (op == 4'd2) return M + 1;
`ifdef ALU_MULTICYCLE_DIV_EN
        if (op == 4'd3) return M + 1;
`endif
        return 1;
    endfunction

    // Scoreboard: every cycle, out_valid/in_ready and (when valid) the result against the model.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ir;
        exp_valid = 1'b0;
        if (exp_q.size() > 0) exp_valid = (cyc >= acc_q[0] + lat_q[0] - 1);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) check("result", {resultado, Z, N, V, C}, exp_q[0]);
        if (!rst_n) exp_ir = 1'b0;
        else if (exp_q.size() == 0) exp_ir = 1'b1;
        else exp_ir = exp_valid && out_ready;
        check("in_ready", in_ready, exp_ir);
        if (exp_valid && out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            void'(lat_q.pop_front());
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(alu_control, a, b));
            acc_q.push_back(cyc + 1);
            lat_q.push_back(model_lat(alu_control));
        end
    end

    // Driver: call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1; alu_control = op; a = x; b = y;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #2;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        note_fail("send_timeout");
    endtask

    task automatic wait_result(input string name, input logic [11:0] exp);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check(name, {resultado, Z, N, V, C}, exp);
                @(posedge clk); #2;
                return;
            end
        end
        note_fail(name);
    endtask

    logic [3:0]  t_op [18] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h4, 4'h5, 4'h1, 4'hF, 4'h9,
                               4'h8, 4'h2, 4'h4, 4'h4, 4'h5, 4'h0, 4'h6, 4'h7};
    logic [7:0]  t_a  [18] = '{8'h7F, 8'h05, 8'h10, 8'hC8, 8'h12, 8'h81, 8'h35, 8'h03, 8'h55, 8'h0F,
                               8'hA5, 8'hFF, 8'h81, 8'h81, 8'h81, 8'hFF, 8'hF0, 8'hF0};
    logic [7:0]  t_b  [18] = '{8'h01, 8'h05, 8'h11, 8'h07, 8'h00, 8'h01, 8'h08, 8'h05, 8'h66, 8'h00,
                               8'hFF, 8'hFF, 8'h00, 8'h08, 8'h01, 8'h01, 8'h3C, 8'h0C};
    logic [11:0] t_exp[18] = '{12'h806, 12'h009, 12'h102, DIV_C8_07, DIV_12_00, 12'h021, 12'h008,
                               12'hFE4, 12'h00A, 12'hF04, 12'h5A0, 12'h012, 12'h814, 12'h009,
                               12'h401, 12'h009, 12'h300, 12'hFC4};

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_control = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", {resultado, Z, N, V, C}, 12'h000);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_state", dbg_state, S_IDLE);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        check("model_add", model(4'h0, 8'h7F, 8'h01), 12'h806);
        check("model_sub", model(4'h1, 8'h05, 8'h05), 12'h009);
        check("model_mul", model(4'h2, 8'h10, 8'h11), 12'h102);
        check("model_sll", model(4'h4, 8'h81, 8'h01), 12'h021);

        @(posedge clk); #2;
        for (int i = 0; i < 18; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            wait_result($sformatf("vec%0d_op%0h", i, t_op[i]), t_exp[i]);
        end

        // Back-to-back chain: each request is accepted on the edge that consumes the previous result.
        send(4'h2, 8'h03, 8'h05);
        send(4'h0, 8'h01, 8'h02);
        send(4'h2, 8'h07, 8'h07);
        send(4'h3, 8'h64, 8'h0A);
        send(4'h8, 8'h3C, 8'hC3);
        wait_result("chain_last_xor", 12'hFF4);

        // Output stall for 5 cycles, then accept on the consuming edge.
        out_ready = 1'b0;
        send(4'h0, 8'h12, 8'h34);
        repeat (5) @(posedge clk);
        #2;
        check("stall_result", {resultado, Z, N, V, C}, 12'h460);
        check("stall_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        send(4'h4, 8'h81, 8'h01);
        wait_result("b2b_sll", 12'h021);

        // Reset in the 4th BUSY cycle of a MUL discards it.
        send(4'h2, 8'h10, 8'h11);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", {resultado, Z, N, V, C}, 12'h000);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_state", dbg_state, S_IDLE);
        exp_q.delete(); acc_q.delete(); lat_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        send(4'h2, 8'h10, 8'h11);
        wait_result("post_rst_mul", 12'h102);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) note_fail("drain");
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter M, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports a, b  input  M  operands, sampled on the accepting edge only.
REQ-005 SHALL have port ALUControl  input  4  opcode, sampled with a and b.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1; a request is accepted on an edge where both are high.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1; a result is consumed on an edge where both are high.
REQ-008 SHALL have ports resultado output M and Z, N, V, C output 1 each, all registered and valid while out_valid is high.

Function
REQ-009 SHALL decode ALUControl as: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 SLL, 0101 SRL, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT(a); 1010-1111 reserved.
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting MUL/DIV; BUSY->DONE when the iteration counter reaches M-1; DONE->IDLE on consume with no new accept.
REQ-011 SHALL drive in_ready high in IDLE, and in DONE when out_ready is high; in_ready is low in BUSY.
REQ-012 SHALL, on a simultaneous consume and accept in DONE, go directly to DONE (single-cycle op) or BUSY (MUL/DIV) with no idle cycle.
REQ-013 SHALL present single-cycle op results with out_valid high on the first edge after acceptance (latency 1).
REQ-014 SHALL compute MUL as unsigned shift-add, one bit per cycle, with out_valid high M+1 edges after acceptance; resultado = low M bits of the product.
REQ-015 SHALL compute DIV as unsigned restoring division, one quotient bit per cycle, with latency M+1; resultado = quotient.
REQ-016 SHALL, for DIV with b = 0, produce resultado all-ones and V = 1 at the normal latency M+1.
REQ-017 SHALL hold resultado, flags and out_valid stable while out_valid is high and out_ready is low.
REQ-018 SHALL set Z = (resultado == 0) and N = resultado[M-1] for every op.
REQ-019 SHALL set, for ADD, C = carry-out and V = signed overflow; for SUB (a + ~b + 1), C = carry-out (1 = no borrow) and V = signed overflow.
REQ-020 SHALL set, for MUL, V = 1 if the upper M product bits are non-zero, else 0, with C = 0.
REQ-021 SHALL use, for SLL/SRL, the unsigned value of b as the shift amount; an amount >= M gives resultado = 0; C = last bit shifted out (0 for an amount of 0); V = 0.
REQ-022 SHALL set C = V = 0 for AND, OR, XOR and NOT.
REQ-023 SHALL complete reserved opcodes with latency 1, resultado = 0, Z = 1, N = C = 0 and V = 1.

Reset
REQ-024 SHALL, on rst_n low, immediately force IDLE, out_valid = 0, resultado = 0, Z = N = V = C = 0, and clear the iteration counter, independent of clk.
REQ-025 SHALL, when reset is asserted in BUSY or DONE, discard the in-flight operation; no result appears after reset is released.
REQ-026 SHALL hold in_ready low while rst_n is low.

Configuration
REQ-027 SHALL, with macro ALU_MULTICYCLE_DIV_EN defined, include the iterative divider per REQ-015/016.
REQ-028 SHALL, with ALU_MULTICYCLE_DIV_EN undefined, instantiate no divider logic and treat opcode 0011 as a reserved opcode per REQ-023.

Structure
REQ-029 SHALL take the opcode enum, FSM state enum and flag-vector typedef from shared package alu_pkg.
REQ-030 SHALL place the MUL/DIV datapath (accumulator, shift registers, counter) in one sub-module, iter_muldiv, parameterised by M and controlled by the top-level FSM.

Verification (M = 8)
REQ-031 SHALL cover: ADD a=0x7F b=0x01 -> resultado 0x80, N=1, V=1, C=0, Z=0, out_valid 1 cycle after accept.
REQ-032 SHALL cover: SUB a=0x05 b=0x05 -> resultado 0x00, Z=1, C=1, V=0.
REQ-033 SHALL cover: MUL a=0x10 b=0x11 -> resultado 0x10, V=1, out_valid exactly 9 edges after accept, in_ready low throughout BUSY.
REQ-034 SHALL cover: DIV a=0xC8 b=0x07 -> 0x1C; DIV a=0x12 b=0x00 -> 0xFF with V=1; with the macro undefined, DIV -> 0x00 with V=1 at latency 1.
REQ-035 SHALL cover: SLL a=0x81 b=0x01 -> 0x02 with C=1; SRL with b=0x08 -> 0x00 with Z=1; out_ready held low 5 cycles -> outputs stable, then back-to-back accept on the consume edge.
REQ-036 SHALL cover: rst_n pulsed low mid-MUL (cycle 4 of BUSY) -> outputs cleared immediately, no out_valid afterwards, next request processes normally.
